uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter between NREQ byte sources. Each source offers bytes over a valid/ready handshake. The arbiter selects one source, latches its byte, and pulses `tx_start` with the byte on `tx_din`. It then waits for the transmitter's `tx_done_tick` before serving the next source. Sources can hold the channel for a multi-byte burst, and a watchdog recovers the arbiter if the transmitter never reports completion.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter and sequencer that shares one uart_tx transmitter
// between NREQ byte sources. A source can lock the channel for a
// multi-byte burst by offering bytes with req_last low. A watchdog abandons
// a transfer whose completion tick never arrives and drops any lock.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 200000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [8*NREQ-1:0]       req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   output logic                    tx_start,
   output logic [7:0]              tx_din,
   input  logic                    tx_done_tick,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    err_timeout
);

   localparam int IDW = $clog2(NREQ);
   localparam int WCW = $clog2(TIMEOUT + 1);

   // Pointer starts at the last requester so that requester 0 wins first.
   localparam logic [IDW-1:0] PTR_RST   = IDW'(NREQ - 1);
   localparam logic [WCW-1:0] WCNT_LAST = WCW'(TIMEOUT - 1);
   localparam logic [WCW-1:0] WCNT_ONE  = WCW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t         r_state;
   logic [IDW-1:0] r_ptr;
   logic           r_lock;
   logic [IDW-1:0] r_lock_id;
   logic [7:0]     r_byte;
   logic [WCW-1:0] r_wcnt;
   logic [IDW-1:0] r_grant;
   logic           r_err;

   logic           w_found;
   logic [IDW-1:0] w_gnt;
   logic [IDW-1:0] w_idx;
   logic           w_accept;
   logic [7:0]     w_byte;
   logic           w_last;

   // Pick the winning candidate: the lock owner alone while locked, otherwise
   // the first valid requester after the pointer, wrapping modulo NREQ.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      if (r_lock) begin
         w_found = req_valid[r_lock_id];
         w_gnt   = r_lock_id;
      end else begin
         for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
               w_found = 1'b1;
               w_gnt   = w_idx;
            end
         end
      end
   end

   // A byte is taken only in IDLE and never while reset is asserted.
   assign w_accept = (r_state == ST_IDLE) && w_found && !reset;
   assign w_byte   = req_data[{w_gnt, 3'b000} +: 8];
   assign w_last   = req_last[w_gnt];

   // One-hot ready strobe for the selected requester during an accept.
   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_gnt] = 1'b1;
      end
   end

   // Arbiter FSM: accept in IDLE, pulse start, then wait for done or timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_ptr     <= PTR_RST;
         r_lock    <= 1'b0;
         r_lock_id <= '0;
         r_byte    <= '0;
         r_wcnt    <= '0;
         r_grant   <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_byte  <= w_byte;
                  r_ptr   <= w_gnt;
                  r_grant <= w_gnt;
                  r_state <= ST_START;
                  // A byte without req_last keeps the channel for its owner.
                  if (w_last) begin
                     r_lock <= 1'b0;
                  end else begin
                     r_lock    <= 1'b1;
                     r_lock_id <= w_gnt;
                  end
               end
            end
            ST_START: begin
               r_wcnt  <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               r_wcnt <= r_wcnt + WCNT_ONE;
               // Completion takes priority over a coincident watchdog expiry.
               if (tx_done_tick) begin
                  r_state <= ST_IDLE;
               end else if (r_wcnt == WCNT_LAST) begin
                  r_err   <= 1'b1;
                  r_lock  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_start    = (r_state == ST_START);
   assign tx_din      = r_byte;
   assign grant_id    = r_grant;
   assign busy        = (r_state != ST_IDLE) || r_lock;
   assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by a randomized
// phase, all checked every cycle against a transaction-timing model.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int TO   = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '0;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_din;
   logic        tx_done_tick = 1'b0;
   logic [1:0]  grant_id;
   logic        busy;
   logic        err_timeout;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .tx_start     (tx_start),
      .tx_din       (tx_din),
      .tx_done_tick (tx_done_tick),
      .grant_id     (grant_id),
      .busy         (busy),
      .err_timeout  (err_timeout)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // requester sources: per-requester FIFO of {last, data}
   logic [8:0] fifo [4][256];
   int         hd [4] = '{0, 0, 0, 0};
   int         tl [4] = '{0, 0, 0, 0};
   logic [3:0] en = '0;

   // transmitter model
   int tx_delay  = 20;
   int cur_delay = 20;
   int done_at   = -1;
   bit spur      = 1'b0;
   bit rand_mode = 1'b0;

   // reference model state
   int         m_ptr      = NREQ - 1;
   bit         m_lock     = 1'b0;
   int         m_lock_id  = 0;
   logic [7:0] m_byte     = '0;
   logic [1:0] m_grant    = '0;
   int         m_idle_at  = 0;
   int         m_start_at = -1;
   int         m_err_at   = -1;
   int         m_unlock_at = -1;

   // observation log
   logic [7:0] log_din [1024];
   logic [1:0] log_gid [1024];
   int         log_cyc [1024];
   int         log_n   = 0;
   int         err_cnt = 0;
   logic [3:0] last_ready = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic l);
      fifo[2'(i)][8'(tl[2'(i)])] = {l, d};
      tl[2'(i)]++;
   endtask

   task automatic flush(input int i);
      hd[2'(i)] = tl[2'(i)];
   endtask

   task automatic randomize_inputs();
      reset    = ($urandom_range(0, 399) == 0);
      tx_delay = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, TO));
      for (int i = 0; i < NREQ; i++) begin
         if (hd[2'(i)] == tl[2'(i)] && $urandom_range(0, 3) == 0)
            push(i, 8'($urandom), ($urandom_range(0, 3) != 0));
         en[2'(i)] = ($urandom_range(0, 15) != 0);
      end
      spur = ((cyc >= m_idle_at) || (cyc == m_start_at)) && ($urandom_range(0, 7) == 0);
   endtask

   // Compare DUT against the model at mid-cycle, then advance the model.
   task automatic model_check();
      int         g;
      logic [3:0] er;
      bit         idle;
      if (cyc == m_unlock_at) m_lock = 1'b0;
      idle = (cyc >= m_idle_at);
      g    = -1;
      er   = '0;
      if (idle && !reset) begin
         if (m_lock) begin
            if (req_valid[2'(m_lock_id)]) g = m_lock_id;
         end else begin
            for (int k = 1; k <= NREQ; k++) begin
               int idx;
               idx = (m_ptr + k) % NREQ;
               if (g < 0 && req_valid[2'(idx)]) g = idx;
            end
         end
         if (g >= 0) er[2'(g)] = 1'b1;
      end
      check("req_ready",   32'(req_ready),   32'(er));
      check("tx_start",    32'(tx_start),    32'(cyc == m_start_at));
      check("tx_din",      32'(tx_din),      32'(m_byte));
      check("grant_id",    32'(grant_id),    32'(m_grant));
      check("busy",        32'(busy),        32'(!idle || m_lock));
      check("err_timeout", 32'(err_timeout), 32'(cyc == m_err_at));

      // environment reactions to what the DUT actually did
      if (req_ready != 4'b0000) last_ready = req_ready;
      if (tx_start) begin
         if (log_n < 1024) begin
            log_din[10'(log_n)] = tx_din;
            log_gid[10'(log_n)] = grant_id;
            log_cyc[10'(log_n)] = cyc;
         end
         log_n++;
         done_at = (cur_delay == 0) ? -1 : cyc + cur_delay;
      end
      if (err_timeout) err_cnt++;
      for (int i = 0; i < NREQ; i++)
         if (req_valid[2'(i)] && req_ready[2'(i)]) hd[2'(i)]++;

      // model update for the next cycle
      if (reset) begin
         m_ptr = NREQ - 1; m_lock = 1'b0; m_lock_id = 0; m_byte = '0; m_grant = '0;
         m_idle_at = cyc + 1; m_start_at = -1; m_err_at = -1; m_unlock_at = -1;
         done_at = -1;
      end else if (g >= 0) begin
         m_byte  = req_data[{2'(g), 3'b000} +: 8];
         m_ptr   = g;
         m_grant = 2'(g);
         if (req_last[2'(g)]) m_lock = 1'b0;
         else begin m_lock = 1'b1; m_lock_id = g; end
         m_start_at = cyc + 1;
         cur_delay  = tx_delay;
         if (cur_delay >= 1 && cur_delay <= TO) begin
            m_idle_at = cyc + cur_delay + 2;
         end else begin
            m_idle_at   = cyc + TO + 2;
            m_err_at    = cyc + TO + 2;
            m_unlock_at = cyc + TO + 2;
         end
      end
   endtask

   task automatic cycle();
      if (rand_mode) randomize_inputs();
      else spur = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (en[2'(i)] && hd[2'(i)] != tl[2'(i)]) begin
            req_valid[2'(i)] = 1'b1;
            req_data[{2'(i), 3'b000} +: 8] = fifo[2'(i)][8'(hd[2'(i)])][7:0];
            req_last[2'(i)] = fifo[2'(i)][8'(hd[2'(i)])][8];
         end else begin
            req_valid[2'(i)] = 1'b0;
         end
      end
      tx_done_tick = (cyc == done_at) || spur;
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic wait_starts(input int n, input int budget);
      int b;
      b = budget;
      while (log_n < n && b > 0) begin
         cycle();
         b--;
      end
      if (log_n < n) check("wait_start", 32'(log_n), 32'(n));
   endtask

   task automatic check_log(input string tag, input int idx, input logic [7:0] d, input logic [1:0] gid);
      check({tag, "_din"}, 32'(log_din[10'(idx)]), 32'(d));
      check({tag, "_gid"}, 32'(log_gid[10'(idx)]), 32'(gid));
   endtask

   initial begin
      int         base;
      int         e0;
      logic [7:0] t1_din [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      logic [1:0] t1_gid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      @(posedge clk);
      #1;
      run(3);
      reset = 1'b0;

      // reset and first grant: all four valid with constant bytes
      for (int i = 0; i < NREQ; i++) begin
         push(i, 8'(8'h10 + i), 1'b1);
         push(i, 8'(8'h10 + i), 1'b1);
      end
      en = 4'b1111;
      wait_starts(5, 200);
      for (int i = 0; i < 5; i++) check_log("rr", i, t1_din[i], t1_gid[i]);
      en = '0;
      for (int i = 0; i < NREQ; i++) flush(i);
      run(30);

      // single requester latency
      base = log_n;
      push(2, 8'hA5, 1'b1);
      en = 4'b0100;
      wait_starts(base + 1, 50);
      check_log("single", base, 8'hA5, 2'd2);
      check("single_ready", 32'(last_ready), 32'(4'b0100));
      en = '0;
      run(25);

      // burst lock with a competing requester and a gap in the burst
      base = log_n;
      push(1, 8'h01, 1'b0);
      push(1, 8'h02, 1'b0);
      push(1, 8'h03, 1'b1);
      en = 4'b0010;
      wait_starts(base + 1, 50);
      push(3, 8'h33, 1'b1);
      en = 4'b1010;
      wait_starts(base + 2, 50);
      en = 4'b1000;
      run(27);
      en = 4'b1010;
      wait_starts(base + 4, 100);
      check_log("burst0", base,     8'h01, 2'd1);
      check_log("burst1", base + 1, 8'h02, 2'd1);
      check_log("burst2", base + 2, 8'h03, 2'd1);
      check_log("burst3", base + 3, 8'h33, 2'd3);
      en = '0;
      run(30);

      // watchdog: missing done, lock dropped, next requester served
      base = log_n;
      push(0, 8'h5A, 1'b0);
      push(2, 8'h77, 1'b1);
      tx_delay = 0;
      en = 4'b0101;
      wait_starts(base + 1, 50);
      tx_delay = 20;
      e0 = err_cnt;
      wait_starts(base + 2, 120);
      check_log("wdog0", base,     8'h5A, 2'd0);
      check_log("wdog1", base + 1, 8'h77, 2'd2);
      check("wdog_err", 32'(err_cnt - e0), 32'd1);
      check("wdog_gap", 32'(log_cyc[10'(base + 1)] - log_cyc[10'(base)]), 32'(TO + 2));
      en = '0;
      flush(0);
      run(30);

      // done on the last watchdog count wins over the timeout
      base = log_n;
      e0 = err_cnt;
      tx_delay = TO;
      push(1, 8'h66, 1'b1);
      en = 4'b0010;
      wait_starts(base + 1, 50);
      run(70);
      check_log("done63", base, 8'h66, 2'd1);
      check("done63_err", 32'(err_cnt - e0), 32'd0);
      tx_delay = 20;
      en = '0;

      // reset in the middle of WAIT
      base = log_n;
      push(3, 8'h99, 1'b1);
      en = 4'b1000;
      wait_starts(base + 1, 50);
      run(6);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rst_gid", 32'(grant_id), 32'd0);
      check("rst_din", 32'(tx_din), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      push(0, 8'h44, 1'b1);
      push(1, 8'h55, 1'b1);
      en = 4'b0011;
      wait_starts(base + 3, 100);
      check_log("rst0", base + 1, 8'h44, 2'd0);
      check_log("rst1", base + 2, 8'h55, 2'd1);
      en = '0;
      run(30);

      // withdrawal during WAIT leaves no trace
      base = log_n;
      push(2, 8'hC3, 1'b1);
      en = 4'b0100;
      wait_starts(base + 1, 50);
      push(0, 8'h0F, 1'b1);
      en = 4'b0101;
      run(5);
      en = '0;
      flush(0);
      run(30);
      check("wd_nstart", 32'(log_n), 32'(base + 1));
      check("wd_gid", 32'(grant_id), 32'd2);

      // randomized traffic
      rand_mode = 1'b1;
      run(4000);
      rand_mode = 1'b0;
      reset = 1'b0;
      en = '0;
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
